gfx_pixel_packer: RTL and testbench
===================================

# gfx_pixel_packer

Converts a stream of full-precision pixels (12-bit R/G/B, 4-bit alpha) into packed memory words in any `color_depth_t` format (BPP6..BPP40). Each component is reduced to its field width, fields are concatenated, and pixels are packed LSB-first into MDW-bit words. It is the write-side counterpart of the pixel unpacker. It sits between the raster/blit pipeline and the memory write port.

## Interface
- MDW, 128: memory word width in bits; must be ≥ 40.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- depth_i  in  4  `color_depth_t` code; sampled only when the accumulator is empty
- pix_valid_i  in  1  pixel valid
- pix_ready_o  out  1  pixel accepted when valid & ready
- pix_r_i, pix_g_i, pix_b_i  in  12 each  colour components
- pix_a_i  in  4  alpha/extra field source
- flush_i  in  1  single-cycle request to emit a partial word
- word_valid_o  out  1  output word valid
- word_ready_i  in  1  downstream accepts word
- word_o  out  MDW  packed word; unused upper bits are zero
- word_cnt_o  out  6  pixels in word_o
- word_last_o  out  1  word was produced by a flush
- err_o  out  1  one-cycle pulse: illegal depth sampled

## Operation
- Field widths: code k (1..12) gives colour width c=k. Alpha width is 2 for k=2; 4 for k=4, 9, 12; otherwise 3. Pixel width W=3c+a.
- Field reduction takes the top c (or a) bits of each component. Pixel bits MSB→LSB are {R,G,B,A}.
- Pixels per word: PPW = floor(MDW/W), a per-code constant fixed at elaboration. For MDW=128: 21, 16, 10, 8, 7, 6, 5, 4, 4, 3, 3, 3 for codes 1..12.
- Pixel n (0-based) of a word occupies bits [n·W+W-1 : n·W].
- Illegal codes (0, 13–15) sampled: treated as BPP16, err_o pulses for one cycle.
- States:
  - EMPTY: accumulator count 0.
  - FILL: 0 < count < PPW.
  - FLUSH: flush pending.
- EMPTY→FILL on an accepted pixel; depth_i is latched on that same cycle.
- FILL→EMPTY when the PPW-th pixel is accepted. The word moves to the output register.
- Any state→FLUSH on flush_i.
  - In FLUSH, pix_ready_o=0.
  - If count>0, the partial word (word_last_o=1) moves to the output register once it is free; then the state goes to EMPTY.
  - If count=0, FLUSH→EMPTY on the next cycle with no word emitted.
- flush_i and an accepted pixel in the same cycle: the pixel is included first, then the flush applies.
- Output register: one entry. It is freed on word_valid_o & word_ready_i, and may reload on the same edge.
- depth_i changes while in FILL are ignored until the accumulator returns to EMPTY.

## Timing
- Reset values: word_valid_o=0, word_o=0, word_cnt_o=0, word_last_o=0, err_o=0, state EMPTY, latched depth=BPP16. After reset, pix_ready_o=1.
- pix_ready_o is 0 in either case:
  - state is FLUSH;
  - count=PPW-1 and the output register is occupied.
- pix_ready_o does not depend combinationally on word_ready_i or pix_valid_i.
- Latency: the pixel completing a word is accepted at edge N; word_valid_o=1 after edge N.
- Throughput: 1 pixel/cycle when downstream holds word_ready_i=1.
- word_o, word_cnt_o and word_last_o are stable while word_valid_o=1 and word_ready_i=0.
- Reset asserted mid-word: the accumulator and output are discarded immediately; no partial word is emitted.

## Configuration
- GFX_PACK_ROUND_EN defined:
  - Each field rounds to nearest: the top bits plus the next lower bit, saturating at all-ones.
  - Adds one pipeline stage before the accumulator, so latency becomes 2 cycles.
  - pix_ready_o rules apply to the stage input.
- GFX_PACK_ROUND_EN undefined: pure truncation, latency 1.

## Test plan
- BPP16, 8 pixels R=ABC G=123 B=FFF A=5 → one word = 8×16'hA1F5; cnt=8; last=0; 1 cycle after the 8th accept.
- BPP6, 21 pixels R=G=B=FFF A=F → word bits[125:0] all ones, bits[127:126]=0, cnt=21.
- BPP40, 2 pixels, then flush_i → word low 80 bits = the two pixels, upper 48=0, cnt=2, last=1. A flush with empty accumulator → no word.
- Backpressure: BPP8 with word_ready_i=0:
  - 16 pixels → word_valid_o=1.
  - 15 more pixels accepted, then pix_ready_o=0.
  - Releasing word_ready_i drains both words in order.
- depth_i=0 → err_o pulses once and the data packs as BPP16. depth_i changed from BPP16 to BPP24 mid-word has no effect until the next word.
- With GFX_PACK_ROUND_EN, BPP8: R=6FF → 2'b10; R=FFF → 2'b11 (saturated); latency 2. Without it: R=6FF → 2'b01.

Source files
------------

// File: rtl/gfx_pixel_packer.sv
// gfx_pixel_packer: reduces 12/12/12/4 pixels to a color_depth_t format and packs them LSB-first into MDW-bit words.
// Optional macro GFX_PACK_ROUND_EN: round-to-nearest field reduction plus one input pipeline stage.
module gfx_pixel_packer #(
   parameter int MDW = 128
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic [3:0]     depth_i,
   input  logic           pix_valid_i,
   output logic           pix_ready_o,
   input  logic [11:0]    pix_r_i,
   input  logic [11:0]    pix_g_i,
   input  logic [11:0]    pix_b_i,
   input  logic [3:0]     pix_a_i,
   input  logic           flush_i,
   output logic           word_valid_o,
   input  logic           word_ready_i,
   output logic [MDW-1:0] word_o,
   output logic [5:0]     word_cnt_o,
   output logic           word_last_o,
   output logic           err_o
);

   typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FLUSH} state_t;

`ifdef GFX_PACK_ROUND_EN
   localparam logic ROUND = 1'b1;
`else
   localparam logic ROUND = 1'b0;
`endif

   function automatic int colorWidth(input logic [3:0] k);
      return int'(k);
   endfunction

   function automatic int alphaWidth(input logic [3:0] k);
      case (k)
         4'd2:                return 2;
         4'd4, 4'd9, 4'd12:   return 4;
         default:             return 3;
      endcase
   endfunction

   function automatic int pixWidth(input logic [3:0] k);
      return 3 * colorWidth(k) + alphaWidth(k);
   endfunction

   // Keeps the top w of srcW bits; rounding adds the next lower bit and saturates at all-ones.
   function automatic logic [11:0] reduceField(input logic [11:0] v, input int srcW, input int w,
                                               input logic rnd);
      logic [11:0] t;
      logic [11:0] maxV;
      logic [11:0] below;
      t    = v >> (srcW - w);
      maxV = 12'hFFF >> (12 - w);
      if (rnd && (w < srcW)) begin
         below = v >> (srcW - 1 - w);
         if (below[0] && (t != maxV))
            t = t + 12'd1;
      end
      return t;
   endfunction

   function automatic logic [39:0] packPixel(input logic [3:0] k, input logic [11:0] r,
                                             input logic [11:0] g, input logic [11:0] b,
                                             input logic [3:0] a);
      int c;
      int aw;
      c  = colorWidth(k);
      aw = alphaWidth(k);
      return (40'(reduceField(r, 12, c, ROUND)) << (2 * c + aw))
           | (40'(reduceField(g, 12, c, ROUND)) << (c + aw))
           | (40'(reduceField(b, 12, c, ROUND)) << aw)
           |  40'(reduceField({8'h00, a}, 4, aw, ROUND));
   endfunction

   logic           w_inValid;
   logic           w_inFlush;
   logic [11:0]    w_inR;
   logic [11:0]    w_inG;
   logic [11:0]    w_inB;
   logic [3:0]     w_inA;
   logic [3:0]     w_inDepth;

   state_t         r_state;
   state_t         w_stateNext;
   logic [5:0]     r_cnt;
   logic [5:0]     w_cntNext;
   logic [5:0]     w_cntPlus;
   logic [5:0]     w_ppw;
   logic [MDW-1:0] r_acc;
   logic [MDW-1:0] w_accNext;
   logic [MDW-1:0] w_accPlus;
   logic [3:0]     r_depth;
   logic [3:0]     w_depthNext;
   logic [3:0]     w_effDepth;
   logic           r_outValid;
   logic           w_outValidNext;
   logic [MDW-1:0] r_out;
   logic [MDW-1:0] w_outNext;
   logic [5:0]     r_outCnt;
   logic [5:0]     w_outCntNext;
   logic           r_outLast;
   logic           w_outLastNext;
   logic           r_err;
   logic           w_errNext;
   logic           w_illegal;
   logic           w_accReady;
   logic           w_take;
   logic [39:0]    w_pix;
   int             w_pixW;

`ifdef GFX_PACK_ROUND_EN
   logic           r_sValid;
   logic           r_sFlush;
   logic [11:0]    r_sR;
   logic [11:0]    r_sG;
   logic [11:0]    r_sB;
   logic [3:0]     r_sA;
   logic [3:0]     r_sDepth;
   logic           w_sFlushTake;

   // The stage carries depth with each pixel and holds a flush until the pixel ahead of it is taken.
   assign w_sFlushTake = r_sFlush && (!r_sValid || w_accReady);
   assign pix_ready_o  = !r_sFlush && (r_state != ST_FLUSH) && (!r_sValid || w_accReady);
   assign w_inValid    = r_sValid;
   assign w_inFlush    = w_sFlushTake;
   assign w_inR        = r_sR;
   assign w_inG        = r_sG;
   assign w_inB        = r_sB;
   assign w_inA        = r_sA;
   assign w_inDepth    = r_sDepth;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sValid <= 1'b0;
         r_sFlush <= 1'b0;
         r_sR     <= '0;
         r_sG     <= '0;
         r_sB     <= '0;
         r_sA     <= '0;
         r_sDepth <= 4'd4;
      end else begin
         if (pix_valid_i && pix_ready_o) begin
            r_sValid <= 1'b1;
            r_sR     <= pix_r_i;
            r_sG     <= pix_g_i;
            r_sB     <= pix_b_i;
            r_sA     <= pix_a_i;
            r_sDepth <= depth_i;
         end else if (r_sValid && w_accReady) begin
            r_sValid <= 1'b0;
         end
         r_sFlush <= (r_sFlush && !w_sFlushTake) || flush_i;
      end
   end
`else
   assign pix_ready_o = w_accReady;
   assign w_inValid   = pix_valid_i;
   assign w_inFlush   = flush_i;
   assign w_inR       = pix_r_i;
   assign w_inG       = pix_g_i;
   assign w_inB       = pix_b_i;
   assign w_inA       = pix_a_i;
   assign w_inDepth   = depth_i;
`endif

   assign w_illegal  = (w_inDepth == 4'd0) || (w_inDepth > 4'd12);
   assign w_effDepth = (r_state == ST_EMPTY) ? (w_illegal ? 4'd4 : w_inDepth) : r_depth;
   assign w_pixW     = pixWidth(w_effDepth);
   assign w_ppw      = 6'(MDW / w_pixW);
   assign w_pix      = packPixel(w_effDepth, w_inR, w_inG, w_inB, w_inA);
   assign w_accPlus  = r_acc | (MDW'(w_pix) << (int'(r_cnt) * w_pixW));
   assign w_cntPlus  = r_cnt + 6'd1;
   // Completing pixel is refused only while the output register still holds a word.
   assign w_accReady = (r_state != ST_FLUSH) && !((w_cntPlus == w_ppw) && r_outValid);
   assign w_take     = w_inValid && w_accReady;

   always_comb begin
      w_stateNext    = r_state;
      w_cntNext      = r_cnt;
      w_accNext      = r_acc;
      w_depthNext    = r_depth;
      w_outValidNext = r_outValid && !word_ready_i;
      w_outNext      = r_out;
      w_outCntNext   = r_outCnt;
      w_outLastNext  = r_outLast;
      w_errNext      = 1'b0;
      case (r_state)
         ST_FLUSH: begin
            if (r_cnt == 6'd0) begin
               w_stateNext = ST_EMPTY;
            end else if (!r_outValid || word_ready_i) begin
               w_outValidNext = 1'b1;
               w_outNext      = r_acc;
               w_outCntNext   = r_cnt;
               w_outLastNext  = 1'b1;
               w_accNext      = '0;
               w_cntNext      = 6'd0;
               w_stateNext    = ST_EMPTY;
            end
         end
         default: begin
            if (w_take) begin
               if (r_state == ST_EMPTY) begin
                  w_depthNext = w_effDepth;
                  w_errNext   = w_illegal;
               end
               if (w_cntPlus == w_ppw) begin
                  w_outValidNext = 1'b1;
                  w_outNext      = w_accPlus;
                  w_outCntNext   = w_cntPlus;
                  w_outLastNext  = 1'b0;
                  w_accNext      = '0;
                  w_cntNext      = 6'd0;
               end else begin
                  w_accNext = w_accPlus;
                  w_cntNext = w_cntPlus;
               end
            end
            if (w_inFlush)
               w_stateNext = ST_FLUSH;
            else
               w_stateNext = (w_cntNext == 6'd0) ? ST_EMPTY : ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_EMPTY;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_depth    <= 4'd4;
         r_outValid <= 1'b0;
         r_out      <= '0;
         r_outCnt   <= '0;
         r_outLast  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_cnt      <= w_cntNext;
         r_acc      <= w_accNext;
         r_depth    <= w_depthNext;
         r_outValid <= w_outValidNext;
         r_out      <= w_outNext;
         r_outCnt   <= w_outCntNext;
         r_outLast  <= w_outLastNext;
         r_err      <= w_errNext;
      end
   end

   assign word_valid_o = r_outValid;
   assign word_o       = r_out;
   assign word_cnt_o   = r_outCnt;
   assign word_last_o  = r_outLast;
   assign err_o        = r_err;

endmodule

// File: tb/tb_gfx_pixel_packer.sv
// Directed-vector bench for gfx_pixel_packer (MDW=128); follows GFX_PACK_ROUND_EN when it is defined.
module tb_gfx_pixel_packer;

   localparam int MDW = 128;
`ifdef GFX_PACK_ROUND_EN
   localparam bit ROUNDING = 1'b1;
`else
   localparam bit ROUNDING = 1'b0;
`endif
   localparam int EXP_LAT = ROUNDING ? 2 : 1;

   logic           clock = 1'b0;
   logic           resetN;
   logic [3:0]     depth;
   logic           pixValid;
   logic           pixReady;
   logic [11:0]    pixR;
   logic [11:0]    pixG;
   logic [11:0]    pixB;
   logic [3:0]     pixA;
   logic           flush;
   logic           wordValid;
   logic           wordReady;
   logic [MDW-1:0] word;
   logic [5:0]     wordCnt;
   logic           wordLast;
   logic           err;

   int checks = 0;
   int errors = 0;
   int errSeen = 0;

   logic [MDW-1:0] gotWord [2];
   logic [5:0]     gotCnt [2];
   int             gotNum;

   gfx_pixel_packer #(.MDW(MDW)) dut (
      .clk_i        (clock),
      .rst_ni       (resetN),
      .depth_i      (depth),
      .pix_valid_i  (pixValid),
      .pix_ready_o  (pixReady),
      .pix_r_i      (pixR),
      .pix_g_i      (pixG),
      .pix_b_i      (pixB),
      .pix_a_i      (pixA),
      .flush_i      (flush),
      .word_valid_o (wordValid),
      .word_ready_i (wordReady),
      .word_o       (word),
      .word_cnt_o   (wordCnt),
      .word_last_o  (wordLast),
      .err_o        (err)
   );

   // Free-running clock, 10 ns period
   always #5 clock = ~clock;

   // Every error pulse is counted so single-cycle pulses are not missed
   always @(negedge clock) if (err) errSeen++;

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts the check and reports any difference
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one pixel and returns just after the edge that accepted it
   task automatic applyStimulus(input logic [11:0] r, input logic [11:0] g, input logic [11:0] b,
                                input logic [3:0] a);
      int n = 0;
      pixR = r;
      pixG = g;
      pixB = b;
      pixA = a;
      pixValid = 1'b1;
      @(negedge clock);
      while (!pixReady && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (!pixReady) checkOutput("acceptTimeout", {127'b0, pixReady}, 128'd1);
      @(posedge clock);
      #1;
      pixValid = 1'b0;
   endtask

   // BPP8 pixel whose packed byte equals v
   task automatic sendByte(input int v);
      logic [7:0] b8;
      b8 = v[7:0];
      applyStimulus({b8[7:6], 10'h0}, {b8[5:4], 10'h0}, {b8[3:2], 10'h0}, {b8[1:0], 2'b00});
   endtask

   task automatic pulseFlush();
      flush = 1'b1;
      @(posedge clock);
      #1;
      flush = 1'b0;
   endtask

   task automatic waitWord(input string tag);
      int n = 0;
      while (!wordValid && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (!wordValid) checkOutput({tag, "Timeout"}, {127'b0, wordValid}, 128'd1);
   endtask

   task automatic consumeWord();
      wordReady = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // Collects up to two handed-off words while wordReady is high
   task automatic collectWords();
      int n = 0;
      gotNum = 0;
      while (gotNum < 2 && n < 60) begin
         @(negedge clock);
         if (wordValid && wordReady) begin
            gotWord[gotNum] = word;
            gotCnt[gotNum]  = wordCnt;
            gotNum++;
         end
         n++;
      end
   endtask

   initial begin
      logic [MDW-1:0] exp0;
      logic [MDW-1:0] exp1;
      longint         t0;
      int             lat;

      resetN = 1'b0;
      depth = 4'd4;
      pixValid = 1'b0;
      pixR = '0;
      pixG = '0;
      pixB = '0;
      pixA = '0;
      flush = 1'b0;
      wordReady = 1'b1;

      // Reset values while reset is held
      repeat (3) @(negedge clock);
      checkOutput("rstValid", {127'b0, wordValid}, 128'd0);
      checkOutput("rstWord", word, 128'd0);
      checkOutput("rstCnt", {122'b0, wordCnt}, 128'd0);
      checkOutput("rstLast", {127'b0, wordLast}, 128'd0);
      checkOutput("rstErr", {127'b0, err}, 128'd0);
      resetN = 1'b1;
      @(negedge clock);
      checkOutput("rstReady", {127'b0, pixReady}, 128'd1);
      @(posedge clock);
      #1;

      // BPP16: eight identical pixels fill one word
      depth = 4'd4;
      for (int i = 0; i < 8; i++) applyStimulus(12'hABC, 12'h123, 12'hFFF, 4'h5);
      lat = 1;
      while (!wordValid && lat < 10) begin
         @(posedge clock);
         #1;
         lat++;
      end
      checkOutput("t1Latency", 128'(lat), 128'(EXP_LAT));
      checkOutput("t1Word", word, ROUNDING ? {8{16'hB1F5}} : {8{16'hA1F5}});
      checkOutput("t1Cnt", {122'b0, wordCnt}, 128'd8);
      checkOutput("t1Last", {127'b0, wordLast}, 128'd0);
      checkOutput("t1NoErr", 128'(errSeen), 128'd0);
      consumeWord();

      // BPP6: 21 all-ones pixels, two top bits stay zero, one pixel per cycle
      depth = 4'd1;
      t0 = $time;
      for (int i = 0; i < 21; i++) applyStimulus(12'hFFF, 12'hFFF, 12'hFFF, 4'hF);
      checkOutput("t2Rate", 128'(($time - t0) / 10), 128'd21);
      waitWord("t2");
      checkOutput("t2Word", word, {2'b00, {126{1'b1}}});
      checkOutput("t2Cnt", {122'b0, wordCnt}, 128'd21);
      consumeWord();

      // BPP40: two pixels then a flush emits a partial word
      depth = 4'd12;
      applyStimulus(12'h123, 12'h456, 12'h789, 4'hA);
      applyStimulus(12'hFED, 12'hCBA, 12'h987, 4'h6);
      pulseFlush();
      waitWord("t3");
      checkOutput("t3Word", word, {48'h0, 40'hFEDCBA9876, 40'h123456789A});
      checkOutput("t3Cnt", {122'b0, wordCnt}, 128'd2);
      checkOutput("t3Last", {127'b0, wordLast}, 128'd1);
      consumeWord();
      pulseFlush();
      checkOutput("t3FlushReady", {127'b0, pixReady}, 128'd0);
      repeat (5) begin
         @(posedge clock);
         #1;
      end
      checkOutput("t3EmptyFlush", {127'b0, wordValid}, 128'd0);
      checkOutput("t3ReadyBack", {127'b0, pixReady}, 128'd1);

      // BPP8 with backpressure: full word waits, second word stalls at its last pixel
      depth = 4'd2;
      wordReady = 1'b0;
      for (int n = 0; n < 16; n++) begin
         exp0[8*n +: 8] = 8'(n);
         exp1[8*n +: 8] = 8'(16 + n);
      end
      for (int i = 0; i < 16; i++) sendByte(i);
      waitWord("t4");
      checkOutput("t4Valid", {127'b0, wordValid}, 128'd1);
      for (int i = 16; i < 31; i++) sendByte(i);
      repeat (2) begin
         @(posedge clock);
         #1;
      end
      checkOutput("t4Stall", {127'b0, pixReady}, ROUNDING ? 128'd1 : 128'd0);
      checkOutput("t4Held", word, exp0);
      wordReady = 1'b1;
      fork
         sendByte(31);
         collectWords();
      join
      checkOutput("t4Drained", 128'(gotNum), 128'd2);
      checkOutput("t4Word0", gotWord[0], exp0);
      checkOutput("t4Word1", gotWord[1], exp1);
      checkOutput("t4Cnt0", {122'b0, gotCnt[0]}, 128'd16);
      checkOutput("t4Cnt1", {122'b0, gotCnt[1]}, 128'd16);
      @(posedge clock);
      #1;

      // Illegal depth code packs as BPP16 and raises one error pulse
      errSeen = 0;
      depth = 4'd0;
      for (int i = 0; i < 8; i++) applyStimulus(12'hF00, 12'h300, 12'hC00, 4'h2);
      waitWord("t5");
      checkOutput("t5Word", word, {8{16'hF3C2}});
      checkOutput("t5ErrOnce", 128'(errSeen), 128'd1);
      consumeWord();

      // Depth change mid-word is ignored until the next word
      depth = 4'd4;
      applyStimulus(12'hF00, 12'h300, 12'hC00, 4'h2);
      depth = 4'd7;
      for (int i = 0; i < 7; i++) applyStimulus(12'hF00, 12'h300, 12'hC00, 4'h2);
      waitWord("t6a");
      checkOutput("t6Word16", word, {8{16'hF3C2}});
      checkOutput("t6Cnt16", {122'b0, wordCnt}, 128'd8);
      consumeWord();
      for (int i = 0; i < 5; i++) applyStimulus(12'hF00, 12'h300, 12'hC00, 4'h2);
      waitWord("t6b");
      checkOutput("t6Word24", word, {8'h00, {5{24'hF06301}}});
      checkOutput("t6Cnt24", {122'b0, wordCnt}, 128'd5);
      consumeWord();

      // BPP8 field reduction of R=6FF and saturating R=FFF
      depth = 4'd2;
      applyStimulus(12'h6FF, 12'h000, 12'h000, 4'h0);
      applyStimulus(12'hFFF, 12'h000, 12'h000, 4'h0);
      pulseFlush();
      waitWord("t7");
      checkOutput("t7Word", word, ROUNDING ? 128'hC080 : 128'hC040);
      checkOutput("t7Last", {127'b0, wordLast}, 128'd1);
      consumeWord();

      // Reset mid-word discards the partial word
      depth = 4'd4;
      for (int i = 0; i < 3; i++) applyStimulus(12'hABC, 12'h123, 12'hFFF, 4'h5);
      resetN = 1'b0;
      @(negedge clock);
      checkOutput("t8RstValid", {127'b0, wordValid}, 128'd0);
      @(posedge clock);
      #1;
      resetN = 1'b1;
      pulseFlush();
      repeat (5) begin
         @(posedge clock);
         #1;
      end
      checkOutput("t8NoPartial", {127'b0, wordValid}, 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
